// File: rtl/gates_chk_pkg.sv
// Shared types, constants and helpers for the gates stimulus/response checker.
package gates_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned GATE_CNT = 6;

    // Vector order table, entry i = {b,a}: 00, 10, 01, 11 listed as (a,b)
    localparam logic [7:0] VEC_TABLE = 8'b11_10_01_00;

    // Expected outputs of the gates block: {y5,y4,y3,y2,y1,y0}
    function automatic logic [GATE_CNT-1:0] exp_gates(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b};
    endfunction

    // Number of set bits in a 6-bit mismatch vector
    function automatic logic [3:0] popcount6(input logic [GATE_CNT-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < GATE_CNT; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/gates_ref_model.sv
// Combinational expected-output model of the two-input gates block.
module gates_ref_model
    import gates_chk_pkg::*;
(
    input  logic                a,
    input  logic                b,
    output logic [GATE_CNT-1:0] exp
);

    // Truth table evaluated directly from the inputs
    always_comb begin
        exp = exp_gates(a, b);
    end

endmodule

// File: rtl/gates_checker.sv
// On-board stimulus/response engine: sweeps a/b over all four vectors,
// compares the gates outputs after a settle time and accumulates errors.
module gates_checker
    import gates_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 10,
    parameter int unsigned NUM_PASSES    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] y_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_mask,
    output logic [7:0] err_count,
    output logic [1:0] vec_idx
);

    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LAST_PASS     = 8'(NUM_PASSES - 1);

    state_t              state;
    logic [7:0]          settle_cnt;
    logic [7:0]          pass_cnt;
    logic                done_q;
    logic [1:0]          ab;
    logic [GATE_CNT-1:0] exp_y;
    logic [GATE_CNT-1:0] mism;
    logic [8:0]          sum;

    // Stimulus comes straight from the vec_idx register, so a/b are glitch-free
    always_comb begin
        ab   = VEC_TABLE[{vec_idx, 1'b0} +: 2];
        a_o  = ab[0];
        b_o  = ab[1];
        busy = (state == SETTLE) || (state == CHECK);
        done = done_q;
        pass = done_q && (err_mask == '0);
    end

    gates_ref_model u_ref (
        .a   (ab[0]),
        .b   (ab[1]),
        .exp (exp_y)
    );

    // Mismatch vector and unsaturated running error sum
    always_comb begin
        mism = y_i ^ exp_y;
        sum  = {1'b0, err_count} + 9'(popcount6(mism));
    end

    // Sequencer: settle each vector, check once, advance vector/pass.
    // done is registered one edge after DONE entry so it rises on the
    // edge after the final check has been folded into the results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            vec_idx    <= '0;
            err_mask   <= '0;
            err_count  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state == DONE) && !start;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_mask   <= '0;
                        err_count  <= '0;
                        vec_idx    <= '0;
                        pass_cnt   <= '0;
                        settle_cnt <= SETTLE_RELOAD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                CHECK: begin
                    err_mask  <= err_mask | mism;
                    err_count <= sum[8] ? 8'hFF : sum[7:0];
                    if (vec_idx != 2'd3) begin
                        vec_idx    <= vec_idx + 2'd1;
                        settle_cnt <= SETTLE_RELOAD;
                        state      <= SETTLE;
                    end else if (pass_cnt < LAST_PASS) begin
                        pass_cnt   <= pass_cnt + 8'd1;
                        vec_idx    <= '0;
                        settle_cnt <= SETTLE_RELOAD;
                        state      <= SETTLE;
                    end else begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gates_checker.sv
// Directed bench for gates_checker with a fault-injectable gates model.
module tb_gates_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start2;
    logic [5:0] y_i, y_i2;
    logic       a_o, b_o, busy, done, pass;
    logic       a2, b2, busy2, done2, pass2;
    logic [5:0] err_mask, err_mask2;
    logic [7:0] err_count, err_count2;
    logic [1:0] vec_idx, vec_idx2;

    logic [5:0] inv_mask;
    logic       stuck0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Hand-written truth table of a good gates block: {y5..y0}
    function automatic logic [5:0] good_y(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 6'h2A;
            2'b10:   return 6'h16;
            2'b01:   return 6'h16;
            default: return 6'h25;
        endcase
    endfunction

    assign y_i  = (good_y(a_o, b_o) ^ inv_mask) & ~{5'b00000, stuck0};
    assign y_i2 = ~good_y(a2, b2);

    gates_checker #(.SETTLE_CYCLES(10), .NUM_PASSES(1)) dut (
        .clk(clk), .reset(reset), .start(start), .y_i(y_i),
        .a_o(a_o), .b_o(b_o), .busy(busy), .done(done), .pass(pass),
        .err_mask(err_mask), .err_count(err_count), .vec_idx(vec_idx)
    );

    gates_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(20)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .y_i(y_i2),
        .a_o(a2), .b_o(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_mask(err_mask2), .err_count(err_count2), .vec_idx(vec_idx2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " a_o"}, 32'(a_o), 0);
        chk({tag, " b_o"}, 32'(b_o), 0);
        chk({tag, " vec_idx"}, 32'(vec_idx), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " pass"}, 32'(pass), 0);
        chk({tag, " err_mask"}, 32'(err_mask), 0);
        chk({tag, " err_count"}, 32'(err_count), 0);
    endtask

    // One run of the main DUT; k counts edges after the start-sampling edge.
    // Optional extra start pulses at p1/p2 and a reset at rst_at.
    task automatic run_seq(input string tag, input int p1, input int p2, input int rst_at,
                           input logic [5:0] exp_mask, input logic [7:0] exp_cnt);
        int busy_cycles;
        int ev;
        busy_cycles = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= 45; k++) begin
            if (k > 0) begin
                if (k == p1 || k == p2) start = 1'b1;
                if (k == rst_at) reset = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                reset = 1'b0;
            end
            if (k == rst_at) begin
                chk_reset_values({tag, " midrun reset"});
                return;
            end
            if (busy) busy_cycles++;
            ev = (k < 44) ? k / 11 : 3;
            chk({tag, " vec_idx"}, 32'(vec_idx), 32'(ev));
            chk({tag, " a_o"}, 32'(a_o), 32'(ev % 2));
            chk({tag, " b_o"}, 32'(b_o), 32'(ev / 2));
            chk({tag, " busy"}, 32'(busy), 32'(k < 44));
            chk({tag, " done"}, 32'(done), 32'(k == 45));
        end
        chk({tag, " busy cycles"}, 32'(busy_cycles), 44);
        chk({tag, " pass"}, 32'(pass), 32'(exp_mask == 6'd0));
        chk({tag, " err_mask"}, 32'(err_mask), 32'(exp_mask));
        chk({tag, " err_count"}, 32'(err_count), 32'(exp_cnt));
    endtask

    initial begin
        int cyc;
        reset    = 1'b1;
        start    = 1'b0;
        start2   = 1'b0;
        inv_mask = '0;
        stuck0   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle stays idle", 32'(busy), 0);

        run_seq("good", -1, -1, -1, 6'b000000, 8'd0);

        inv_mask = 6'b010000;
        run_seq("y4 inverted", -1, -1, -1, 6'b010000, 8'd4);

        inv_mask = '0;
        stuck0   = 1'b1;
        run_seq("y0 stuck0", -1, -1, -1, 6'b000001, 8'd1);

        stuck0 = 1'b0;
        run_seq("restart from done", -1, -1, -1, 6'b000000, 8'd0);

        inv_mask = 6'b010000;
        run_seq("reset run", -1, -1, 20, 6'b000000, 8'd0);
        inv_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("after reset idle");

        run_seq("post-reset good", -1, -1, -1, 6'b000000, 8'd0);

        run_seq("start while busy", 5, 30, -1, 6'b000000, 8'd0);

        // Saturation: all outputs inverted, 20 passes of 1-cycle settle
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("sat done edge", 32'(cyc), 161);
        chk("sat done", 32'(done2), 1);
        chk("sat err_count", 32'(err_count2), 255);
        chk("sat err_mask", 32'(err_mask2), 32'h3F);
        chk("sat pass", 32'(pass2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gates_checker.md
Name: gates_checker

Overview:
- Synthesizable, self-checking stimulus/response engine for the two-input `gates` block (outputs y0..y5).
- Drives a/b through all four input vectors in order 00, 10, 01, 11, where each pair is listed as (a,b).
- After a programmable settle time, samples y0..y5, compares them against the expected truth table, and accumulates per-gate error flags and a mismatch count.
- Sits on the FPGA board next to `gates`; its done/pass results go to LEDs, replacing simulation-only checking.

Parameters:
- SETTLE_CYCLES, 10: clk cycles each vector is held before sampling; legal range is 1 to 255.
- NUM_PASSES, 1: number of full 4-vector sweeps per start; legal range is 1 to 255.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- y_i  input  6  gate outputs from `gates`: {y5,y4,y3,y2,y1,y0}
- a_o  output  1  stimulus to `gates` port a
- b_o  output  1  stimulus to `gates` port b
- busy  output  1  high in SETTLE or CHECK
- done  output  1  high while in DONE; held until next start or reset
- pass  output  1  equals done && (err_mask == 0)
- err_mask  output  6  sticky per-gate mismatch flags; bit n corresponds to yn
- err_count  output  8  total mismatched bits in the run; saturates at 255
- vec_idx  output  2  index of the vector being driven; a_o = vec_idx[0], b_o = vec_idx[1]

Behaviour:
- Expected outputs:
  - y0 = a&b, y1 = ~(a&b), y2 = a|b
  - y3 = ~(a|b), y4 = a^b, y5 = ~(a^b)
- Reset values (all outputs): a_o=0, b_o=0, vec_idx=0, busy=0, done=0, pass=0, err_mask=0, err_count=0. State is IDLE, pass counter is 0, settle counter is 0.
- IDLE:
  - On start=1: clear err_mask and err_count, set vec_idx=0, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - Hold vector.
  - Counter at 0 -> go to CHECK; otherwise decrement.
- CHECK (exactly 1 cycle):
  - mism = y_i ^ expected(vec_idx).
  - err_mask |= mism.
  - err_count = min(255, err_count + popcount(mism)).
  - Then:
    - If vec_idx < 3: increment vec_idx, reload counter, go to SETTLE.
    - Else if pass counter < NUM_PASSES-1: increment pass counter, set vec_idx=0, reload counter, go to SETTLE.
    - Else: go to DONE.
- DONE:
  - done=1; a_o/b_o hold the last vector.
  - start=1 behaves as in IDLE (clears results, restarts at vec 0, pass counter 0).
- Timing:
  - Each vector occupies SETTLE_CYCLES + 1 cycles.
  - done rises NUM_PASSES*4*(SETTLE_CYCLES+1) + 1 clock edges after the edge that samples start.
- start while busy is ignored; results are not disturbed.
- Saturation: err_count holds at 255 when the sum would exceed 255. err_mask remains accurate.
- Reset at any time, including mid-run: returns to reset values on the next edge. A partial run leaves no residue.
- a_o/b_o are registered outputs, glitch-free, and change only on a SETTLE entry edge.
- y_i is treated as synchronous, i.e. `gates` is combinational from a_o/b_o. No synchronizer is used.

Decomposition:
- Package gates_chk_pkg:
  - State enum IDLE/SETTLE/CHECK/DONE (2-bit encoding).
  - Constant GATE_CNT=6.
  - Constant vector order table.
  - Function exp_gates(a,b) returning 6 bits.
  - Function popcount6.
- One sub-module, gates_ref_model: combinational expected-output model with inputs a,b and output exp[5:0]. Instantiated inside gates_checker and reusable by benches.

Test Plan:
- Good `gates` attached, SETTLE_CYCLES=10, NUM_PASSES=1, start pulsed 1 cycle -> done=1 and pass=1 at edge 45 after start; err_mask=0, err_count=0; busy high for 44 cycles; (a_o,b_o) sequence is 00, 10, 01, 11, each held 11 cycles.
- y4 forced inverted -> done=1, pass=0, err_mask=6'b010000, err_count=4.
- y0 stuck at 0 -> err_mask=6'b000001, err_count=1 (mismatch only on vector 11); second start from DONE with good DUT -> err_count=0, pass=1.
- All y_i inverted, SETTLE_CYCLES=1, NUM_PASSES=20 (480 raw mismatches) -> err_count=255 (saturated), err_mask=6'b111111, pass=0.
- reset asserted for 1 cycle at cycle 20 of a run -> next edge gives IDLE with all outputs at reset values; later start completes normally with pass=1.
- start re-pulsed at cycles 5 and 30 mid-run -> ignored; done still at edge 45; results identical to scenario 1.
